// File: rtl/k005297_bootsync_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : k005297_bootsync_sequencer
// Purpose  : Boot-time sync sequencer for the bubble-memory access-mode logic.
//            After a CPU start command, it hunts the serial bubble-data-in
//            (BDI) stream for the page sync word. When it finds the word it
//            pulses SYNCED_FLAG_SET_n. In bootloader mode it then drains one
//            page of valid bits and issues the combined CMDREG_RST_n /
//            BDI_EN_SET_n handoff strobe, which selects user mode. All state
//            advances only on 2 MHz clock-enable ticks.
// Ports    : i_MCLK              master clock
//            i_SYS_RST_n         asynchronous active-low reset
//            i_CLK2M_PCEN_n      active-low tick enable
//            i_SYS_RUN_FLAG      0 forces IDLE on any tick
//            i_BMODE_n           0 = bootloader mode, 1 = user mode
//            i_CMD_START         start request (ignored while busy)
//            i_BDI, i_BDI_VALID  serial data bit and its qualifier
//            o_SYNCED_FLAG_SET_n one-tick low pulse on sync match
//            o_CMDREG_RST_n      one-tick low pulse at handoff
//            o_BDI_EN_SET_n      one-tick low pulse at handoff
//            o_SYNC_TIMEOUT      sticky hunt-timeout flag
//            o_BUSY              high whenever the sequencer is not IDLE
// Revision : 1.0  initial release
// ============================================================================
module k005297_bootsync_sequencer #(
  parameter int                  SYNC_LEN     = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT     = 16'h2D4B,
  parameter int                  TIMEOUT_BITS = 1024,
  parameter int                  PAGE_BITS    = 512
) (
  input  logic i_MCLK,
  input  logic i_SYS_RST_n,
  input  logic i_CLK2M_PCEN_n,
  input  logic i_SYS_RUN_FLAG,
  input  logic i_BMODE_n,
  input  logic i_CMD_START,
  input  logic i_BDI,
  input  logic i_BDI_VALID,
  output logic o_SYNCED_FLAG_SET_n,
  output logic o_CMDREG_RST_n,
  output logic o_BDI_EN_SET_n,
  output logic o_SYNC_TIMEOUT,
  output logic o_BUSY
);

  localparam int CNT_MAX = (TIMEOUT_BITS > PAGE_BITS) ? TIMEOUT_BITS : PAGE_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_BITS);
  localparam logic [CNT_W-1:0] PAGE_CNT    = CNT_W'(PAGE_BITS);
  localparam logic [CNT_W-1:0] SYNC_CNT    = CNT_W'(SYNC_LEN);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HUNT    = 3'd1,
    ST_SYNCED  = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HANDOFF = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [SYNC_LEN-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]    bitcnt, bitcnt_nxt;
  logic                synced_n, synced_n_nxt;
  logic                cmdreg_n, cmdreg_n_nxt;
  logic                bdi_en_n, bdi_en_n_nxt;
  logic                timeout, timeout_nxt;
  logic                busy, busy_nxt;

  logic                tick;
  logic [SYNC_LEN-1:0] shift_val;
  logic [CNT_W-1:0]    cnt_inc;

  assign tick      = ~i_CLK2M_PCEN_n;
  // Candidate shift value includes the bit arriving on this tick, so a match
  // is recognised on the same tick the final sync bit is accepted.
  assign shift_val = {shreg[SYNC_LEN-2:0], i_BDI};
  // The counter saturates instead of wrapping. Both HUNT and DRAIN leave
  // before the ceiling is reached, so saturation is only a safety net.
  assign cnt_inc   = (bitcnt == CNT_SAT) ? bitcnt : bitcnt + CNT_W'(1);

  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      synced_n <= 1'b1;
      cmdreg_n <= 1'b1;
      bdi_en_n <= 1'b1;
      timeout  <= 1'b0;
      busy     <= 1'b0;
    end else if (tick) begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bitcnt   <= bitcnt_nxt;
      synced_n <= synced_n_nxt;
      cmdreg_n <= cmdreg_n_nxt;
      bdi_en_n <= bdi_en_n_nxt;
      timeout  <= timeout_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state logic is evaluated as if the current cycle were a tick. The
  // register block above commits it only on real ticks. The strobes default
  // high so that every low pulse lasts exactly one tick period.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bitcnt_nxt   = bitcnt;
    synced_n_nxt = 1'b1;
    cmdreg_n_nxt = 1'b1;
    bdi_en_n_nxt = 1'b1;
    timeout_nxt  = timeout;

    if (!i_SYS_RUN_FLAG) begin
      // Losing the run flag overrides everything, including a same-tick
      // match. The timeout flag is left untouched.
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_CMD_START) begin
            state_nxt   = ST_HUNT;
            shreg_nxt   = '0;
            bitcnt_nxt  = '0;
            timeout_nxt = 1'b0;
          end
        end

        ST_HUNT: begin
          if (i_BDI_VALID) begin
            shreg_nxt  = shift_val;
            bitcnt_nxt = cnt_inc;
            // Match is tested before timeout so that a sync word ending
            // exactly on the last allowed bit still counts.
            if ((shift_val == SYNC_PAT) && (cnt_inc >= SYNC_CNT)) begin
              state_nxt    = ST_SYNCED;
              synced_n_nxt = 1'b0;
            end else if (cnt_inc == TIMEOUT_CNT) begin
              state_nxt   = ST_IDLE;
              timeout_nxt = 1'b1;
            end
          end
        end

        ST_SYNCED: begin
          if (!i_BMODE_n) begin
            state_nxt  = ST_DRAIN;
            bitcnt_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (i_BDI_VALID) begin
            bitcnt_nxt = cnt_inc;
            if (cnt_inc == PAGE_CNT) begin
              state_nxt    = ST_HANDOFF;
              cmdreg_n_nxt = 1'b0;
              bdi_en_n_nxt = 1'b0;
            end
          end
        end

        ST_HANDOFF: begin
          state_nxt = ST_IDLE;
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  assign o_SYNCED_FLAG_SET_n = synced_n;
  assign o_CMDREG_RST_n      = cmdreg_n;
  assign o_BDI_EN_SET_n      = bdi_en_n;
  assign o_SYNC_TIMEOUT      = timeout;
  assign o_BUSY              = busy;

endmodule
`default_nettype wire

// File: tb/tb_k005297_bootsync_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_k005297_bootsync_sequencer
// Purpose  : Self-checking bench for k005297_bootsync_sequencer. It combines
//            a hand-written vector table, directed multi-cycle sequences and
//            randomized traffic. All of them are checked against a
//            bit-history reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_k005297_bootsync_sequencer;

  localparam logic [15:0] PAT_C  = 16'h2D4B;
  localparam int          TMO_C  = 1024;
  localparam int          PAGE_C = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen_n = 1'b1;
  logic run = 1'b0;
  logic bmode_n = 1'b1;
  logic start = 1'b0;
  logic bdi = 1'b0;
  logic bdi_valid = 1'b0;
  logic synced_n, cmdreg_n, bdi_en_n, sync_tmo, busy;

  always #5 clk = ~clk;

  k005297_bootsync_sequencer dut (
    .i_MCLK              (clk),
    .i_SYS_RST_n         (rst_n),
    .i_CLK2M_PCEN_n      (cen_n),
    .i_SYS_RUN_FLAG      (run),
    .i_BMODE_n           (bmode_n),
    .i_CMD_START         (start),
    .i_BDI               (bdi),
    .i_BDI_VALID         (bdi_valid),
    .o_SYNCED_FLAG_SET_n (synced_n),
    .o_CMDREG_RST_n      (cmdreg_n),
    .o_BDI_EN_SET_n      (bdi_en_n),
    .o_SYNC_TIMEOUT      (sync_tmo),
    .o_BUSY              (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model keeps the literal history of bits received since the start
  // command and a countdown of page bits still to drain.
  localparam int M_IDLE = 0, M_HUNT = 1, M_SYNCED = 2, M_DRAIN = 3, M_HANDOFF = 4;
  int  ph = M_IDLE;
  bit  hist[$];
  int  drain_left = 0;
  bit  e_sync = 1, e_cmd = 1, e_bden = 1, e_tmo = 0, e_busy = 0;

  function automatic bit tail_is_sync();
    logic [15:0] v;
    v = '0;
    if (hist.size() < 16) return 1'b0;
    for (int i = 0; i < 16; i++) v = {v[14:0], hist[hist.size() - 16 + i]};
    return v == PAT_C;
  endfunction

  task automatic m_reset();
    ph = M_IDLE; hist.delete(); drain_left = 0;
    e_sync = 1; e_cmd = 1; e_bden = 1; e_tmo = 0; e_busy = 0;
  endtask

  task automatic m_step(input bit c, input bit r, input bit s, input bit bm, input bit d, input bit v);
    if (!c) return;
    e_sync = 1; e_cmd = 1; e_bden = 1;
    if (!r) ph = M_IDLE;
    else if (ph == M_IDLE) begin
      if (s) begin ph = M_HUNT; hist.delete(); e_tmo = 0; end
    end else if (ph == M_HUNT) begin
      if (v) begin
        hist.push_back(d);
        if (tail_is_sync()) begin ph = M_SYNCED; e_sync = 0; end
        else if (hist.size() == TMO_C) begin ph = M_IDLE; e_tmo = 1; end
      end
    end else if (ph == M_SYNCED) begin
      if (bm) ph = M_IDLE;
      else begin ph = M_DRAIN; drain_left = PAGE_C; end
    end else if (ph == M_DRAIN) begin
      if (v) begin
        drain_left--;
        if (drain_left == 0) begin ph = M_HANDOFF; e_cmd = 0; e_bden = 0; end
      end
    end else ph = M_IDLE;
    e_busy = (ph != M_IDLE);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".synced_n"}, synced_n, e_sync);
    check({tag, ".cmdreg_n"}, cmdreg_n, e_cmd);
    check({tag, ".bdi_en_n"}, bdi_en_n, e_bden);
    check({tag, ".timeout"},  sync_tmo, e_tmo);
    check({tag, ".busy"},     busy,     e_busy);
  endtask

  // One clock cycle: drive inputs, clock, advance model, sample 1 ns later.
  task automatic step(input bit c, input bit r, input bit s, input bit bm, input bit d, input bit v);
    cen_n = !c; run = r; start = s; bmode_n = bm; bdi = d; bdi_valid = v;
    @(posedge clk);
    m_step(c, r, s, bm, d, v);
    #1;
    compare_model("model");
  endtask

  task automatic feed(input logic [15:0] val, input int n, input bit bm);
    for (int i = n - 1; i >= 0; i--) step(1, 1, 0, bm, val[i], 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit   c, r, s, bm, d, v;
    logic x_sync, x_cmd, x_bden, x_tmo, x_busy;
  } vec_t;
  vec_t vecs[8];

  logic [15:0] pat;
  int inj;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pat = PAT_C;
    // c r s bm d v | sync cmd bden tmo busy
    vecs[0] = '{0,1,1,0,0,0, 1,1,1,0,0}; // no tick: start ignored
    vecs[1] = '{1,0,1,0,0,0, 1,1,1,0,0}; // start with run=0 stays idle
    vecs[2] = '{1,1,1,0,0,0, 1,1,1,0,1}; // start -> HUNT
    vecs[3] = '{0,1,0,0,1,1, 1,1,1,0,1}; // CEN gap: nothing changes
    vecs[4] = '{1,1,1,0,0,0, 1,1,1,0,1}; // start while busy ignored
    vecs[5] = '{1,0,0,0,0,0, 1,1,1,0,0}; // run drop -> IDLE
    vecs[6] = '{1,1,1,1,0,0, 1,1,1,0,1}; // restart
    vecs[7] = '{1,0,0,1,0,0, 1,1,1,0,0}; // run drop again

    // Reset state
    #12;
    check("rst.synced_n", synced_n, 1'b1);
    check("rst.cmdreg_n", cmdreg_n, 1'b1);
    check("rst.bdi_en_n", bdi_en_n, 1'b1);
    check("rst.timeout",  sync_tmo, 1'b0);
    check("rst.busy",     busy,     1'b0);
    #8 rst_n = 1'b1;
    m_reset();
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      cen_n = !vecs[i].c; run = vecs[i].r; start = vecs[i].s;
      bmode_n = vecs[i].bm; bdi = vecs[i].d; bdi_valid = vecs[i].v;
      @(posedge clk);
      m_step(vecs[i].c, vecs[i].r, vecs[i].s, vecs[i].bm, vecs[i].d, vecs[i].v);
      #1;
      check($sformatf("vec%0d.synced_n", i), synced_n, vecs[i].x_sync);
      check($sformatf("vec%0d.cmdreg_n", i), cmdreg_n, vecs[i].x_cmd);
      check($sformatf("vec%0d.bdi_en_n", i), bdi_en_n, vecs[i].x_bden);
      check($sformatf("vec%0d.timeout", i),  sync_tmo, vecs[i].x_tmo);
      check($sformatf("vec%0d.busy", i),     busy,     vecs[i].x_busy);
    end

    // Bootloader: 5 noise bits, sync word, gaps, then a 512-bit page
    step(1, 1, 1, 0, 0, 0);
    feed(16'b10110, 5, 0);
    step(1, 1, 0, 0, 1, 0);   // valid gap
    step(0, 1, 1, 0, 1, 1);   // CEN gap
    feed(pat, 16, 0);
    check("boot.sync_pulse", synced_n, 1'b0);
    step(1, 1, 0, 0, 0, 0);   // SYNCED tick
    check("boot.sync_release", synced_n, 1'b1);
    for (int i = 0; i < PAGE_C; i++) begin
      if (i % 97 == 5) step(0, 1, 0, 0, 0, 1);
      if (i % 61 == 7) step(1, 1, 1, 0, 0, 0);   // start + no valid
      step(1, 1, (i % 50) == 3, 0, i[0], 1);
      if (i == PAGE_C - 2) check("boot.no_early_handoff", cmdreg_n, 1'b1);
    end
    check("boot.cmdreg_pulse", cmdreg_n, 1'b0);
    check("boot.bden_pulse",   bdi_en_n, 1'b0);
    step(1, 1, 0, 0, 0, 0);
    check("boot.handoff_idle", busy, 1'b0);
    check("boot.cmdreg_release", cmdreg_n, 1'b1);

    // User mode: one SYNCED pulse, no handoff
    step(1, 1, 1, 1, 0, 0);
    feed(16'b01001, 5, 1);
    feed(pat, 16, 1);
    check("user.sync_pulse", synced_n, 1'b0);
    step(1, 1, 0, 1, 0, 1);
    check("user.idle", busy, 1'b0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 1, 1, 1);

    // Timeout, then match on the final allowed bit
    step(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < TMO_C; i++) step(1, 1, 0, 1, 0, 1);
    check("tmo.flag", sync_tmo, 1'b1);
    check("tmo.idle", busy, 1'b0);
    step(1, 1, 1, 1, 0, 0);
    check("tmo.cleared", sync_tmo, 1'b0);
    for (int i = 0; i < TMO_C - 16; i++) step(1, 1, 0, 1, 0, 1);
    feed(pat, 16, 1);
    check("tmo.match_wins", synced_n, 1'b0);
    check("tmo.no_flag", sync_tmo, 1'b0);
    step(1, 1, 0, 1, 0, 0);

    // Run dropped on the final sync bit
    step(1, 1, 1, 1, 0, 0);
    for (int i = 15; i >= 1; i--) step(1, 1, 0, 1, pat[i], 1);
    step(1, 0, 0, 1, pat[0], 1);
    check("run.no_sync", synced_n, 1'b1);
    check("run.idle", busy, 1'b0);
    step(1, 0, 1, 1, 0, 0);
    check("run.start_blocked", busy, 1'b0);

    // Asynchronous reset in the middle of DRAIN
    step(1, 1, 1, 0, 0, 0);
    feed(pat, 16, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(1, 1, 0, 0, 1, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst.busy",     busy,     1'b0);
    check("arst.cmdreg_n", cmdreg_n, 1'b1);
    check("arst.bdi_en_n", bdi_en_n, 1'b1);
    check("arst.synced_n", synced_n, 1'b1);
    m_reset();
    #11 rst_n = 1'b1;
    for (int i = 0; i < 600; i++) step(1, 1, 0, 0, 1, 1);

    // Randomized traffic with injected sync words
    inj = 0;
    for (int n = 0; n < 6000; n++) begin
      bit c, r, s, bm, d, v;
      c  = ($urandom_range(0, 9) < 8);
      r  = ($urandom_range(0, 999) >= 3);
      s  = ($urandom_range(0, 99) < 5);
      bm = $urandom_range(0, 1);
      v  = ($urandom_range(0, 9) < 7);
      d  = $urandom_range(0, 1);
      if (inj == 0 && $urandom_range(0, 99) < 3) inj = 16;
      if (inj > 0 && c && v) begin
        d = pat[inj - 1];
        inj--;
      end
      step(c, r, s, bm, d, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
